// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared state type and address helpers for the data cache
package dcache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WRITEBACK,
        ST_REFILL_REQ,
        ST_REFILL_WAIT
    } dc_state_t;

    // Number of bits needed to select one of n items (at least one bit)
    function automatic int field_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Word offset within a line; the caller narrows the result to its own width
    function automatic logic [31:0] addr_offset(input logic [31:0] addr, input int offset_w);
        return (addr >> 2) & ((32'd1 << offset_w) - 32'd1);
    endfunction

    // Line index sitting directly above the word offset
    function automatic logic [31:0] addr_index(input logic [31:0] addr, input int offset_w,
                                               input int index_w);
        return (addr >> (offset_w + 2)) & ((32'd1 << index_w) - 32'd1);
    endfunction

    // Everything above the index is tag
    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int offset_w,
                                             input int index_w);
        return addr >> (offset_w + index_w + 2);
    endfunction

endpackage

// File: rtl/dcache_data_ram.sv
// rtl/dcache_data_ram.sv - cache data array, combinational read, byte-enabled synchronous write
module dcache_data_ram #(
    parameter int NUM_SETS       = 16,
    parameter int WORDS_PER_LINE = 16,
    parameter int INDEX_W        = 4,
    parameter int OFFSET_W       = 4
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [INDEX_W-1:0]  wr_set,
    input  logic [OFFSET_W-1:0] wr_word,
    input  logic [3:0]          wr_be,
    input  logic [31:0]         wr_data,
    input  logic [INDEX_W-1:0]  rd_set,
    input  logic [OFFSET_W-1:0] rd_word,
    output logic [31:0]         rd_data
);

    logic [31:0] mem [NUM_SETS*WORDS_PER_LINE];

    assign rd_data = mem[{rd_set, rd_word}];

    // Byte-lane write; contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[{wr_set, wr_word}][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dcache_wb_ctrl.sv
// rtl/dcache_wb_ctrl.sv - direct-mapped write-back write-allocate data cache controller
module dcache_wb_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_SETS       = 16,
    parameter int WORDS_PER_LINE = 16,
    parameter int STAT_W         = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic              cpu_req_we,
    input  logic [31:0]       cpu_req_addr,
    input  logic [31:0]       cpu_req_wdata,
    input  logic [3:0]        cpu_req_be,
    output logic              cpu_resp_valid,
    output logic [31:0]       cpu_resp_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [31:0]       mem_req_addr,
    output logic [31:0]       mem_req_wdata,
    input  logic              mem_resp_valid,
    input  logic [31:0]       mem_resp_rdata,
    output logic [STAT_W-1:0] stat_hits,
    output logic [STAT_W-1:0] stat_misses
);

    localparam int INDEX_W  = field_width(NUM_SETS);
    localparam int OFFSET_W = field_width(WORDS_PER_LINE);
    localparam int TAG_W    = 30 - INDEX_W - OFFSET_W;

    dc_state_t           state_q, state_d;

    logic [31:0]         req_addr_q;
    logic [31:0]         req_wdata_q;
    logic                req_we_q;
    logic [3:0]          req_be_q;
    logic                first_q;
    logic [OFFSET_W-1:0] beat_q;

    logic [NUM_SETS-1:0] valid_q;
    logic [NUM_SETS-1:0] dirty_q;
    logic [TAG_W-1:0]    tag_q [NUM_SETS];
    logic [STAT_W-1:0]   hits_q, misses_q;

    logic [INDEX_W-1:0]  req_index;
    logic [OFFSET_W-1:0] req_offset;
    logic [TAG_W-1:0]    req_tag;
    logic                hit;
    logic                last_beat;

    logic                ram_we;
    logic [3:0]          ram_be;
    logic [31:0]         ram_wdata;
    logic [OFFSET_W-1:0] ram_wr_word;
    logic [OFFSET_W-1:0] ram_rd_word;
    logic [31:0]         ram_rdata;

    assign req_offset = OFFSET_W'(addr_offset(req_addr_q, OFFSET_W));
    assign req_index  = INDEX_W'(addr_index(req_addr_q, OFFSET_W, INDEX_W));
    assign req_tag    = TAG_W'(addr_tag(req_addr_q, OFFSET_W, INDEX_W));
    assign hit        = valid_q[req_index] && (tag_q[req_index] == req_tag);
    assign last_beat  = (beat_q == OFFSET_W'(WORDS_PER_LINE - 1));

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;

    dcache_data_ram #(
        .NUM_SETS      (NUM_SETS),
        .WORDS_PER_LINE(WORDS_PER_LINE),
        .INDEX_W       (INDEX_W),
        .OFFSET_W      (OFFSET_W)
    ) u_data_ram (
        .clk    (clk),
        .wr_en  (ram_we),
        .wr_set (req_index),
        .wr_word(ram_wr_word),
        .wr_be  (ram_be),
        .wr_data(ram_wdata),
        .rd_set (req_index),
        .rd_word(ram_rd_word),
        .rd_data(ram_rdata)
    );

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: lookup decides hit / writeback / refill, refill ends in a replay lookup
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req_valid) state_d = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                if (hit)                                          state_d = ST_IDLE;
                else if (valid_q[req_index] && dirty_q[req_index]) state_d = ST_WRITEBACK;
                else                                              state_d = ST_REFILL_REQ;
            end
            ST_WRITEBACK: begin
                if (mem_req_ready && last_beat) state_d = ST_REFILL_REQ;
            end
            ST_REFILL_REQ: begin
                if (mem_req_ready) state_d = ST_REFILL_WAIT;
            end
            ST_REFILL_WAIT: begin
                if (mem_resp_valid) state_d = last_beat ? ST_LOOKUP : ST_REFILL_REQ;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: CPU handshake, memory beat request and data-array port steering
    always_comb begin
        cpu_req_ready  = 1'b0;
        cpu_resp_valid = 1'b0;
        cpu_resp_rdata = '0;
        mem_req_valid  = 1'b0;
        mem_req_we     = 1'b0;
        mem_req_addr   = '0;
        mem_req_wdata  = '0;
        ram_we         = 1'b0;
        ram_be         = '0;
        ram_wdata      = '0;
        ram_wr_word    = req_offset;
        ram_rd_word    = req_offset;
        case (state_q)
            ST_IDLE: begin
                cpu_req_ready = 1'b1;
            end
            ST_LOOKUP: begin
                if (hit) begin
                    cpu_resp_valid = 1'b1;
                    if (req_we_q) begin
                        ram_we    = 1'b1;
                        ram_be    = req_be_q;
                        ram_wdata = req_wdata_q;
                    end else begin
                        cpu_resp_rdata = ram_rdata;
                    end
                end
            end
            ST_WRITEBACK: begin
                ram_rd_word   = beat_q;
                mem_req_valid = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = {tag_q[req_index], req_index, beat_q, 2'b00};
                mem_req_wdata = ram_rdata;
            end
            ST_REFILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {req_tag, req_index, beat_q, 2'b00};
            end
            ST_REFILL_WAIT: begin
                if (mem_resp_valid) begin
                    ram_we      = 1'b1;
                    ram_be      = 4'hF;
                    ram_wdata   = mem_resp_rdata;
                    ram_wr_word = beat_q;
                end
            end
            default: ;
        endcase
    end

    // Request capture, beat counter and per-line valid/dirty bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_we_q    <= 1'b0;
            req_be_q    <= '0;
            first_q     <= 1'b0;
            beat_q      <= '0;
            valid_q     <= '0;
            dirty_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cpu_req_valid) begin
                        req_addr_q  <= cpu_req_addr;
                        req_wdata_q <= cpu_req_wdata;
                        req_we_q    <= cpu_req_we;
                        req_be_q    <= cpu_req_be;
                        first_q     <= 1'b1;
                    end
                end
                ST_LOOKUP: begin
                    first_q <= 1'b0;
                    beat_q  <= '0;
                    if (hit && req_we_q && (req_be_q != 4'b0000)) dirty_q[req_index] <= 1'b1;
                end
                ST_WRITEBACK: begin
                    if (mem_req_ready) beat_q <= beat_q + OFFSET_W'(1);
                end
                ST_REFILL_WAIT: begin
                    if (mem_resp_valid) begin
                        beat_q <= beat_q + OFFSET_W'(1);
                        if (last_beat) begin
                            valid_q[req_index] <= 1'b1;
                            dirty_q[req_index] <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag is installed with the final refill word; no reset since valid guards it
    always_ff @(posedge clk) begin
        if (state_q == ST_REFILL_WAIT && mem_resp_valid && last_beat) begin
            tag_q[req_index] <= req_tag;
        end
    end

    // Saturating hit/miss counters, only the first lookup of each request counts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else if (state_q == ST_LOOKUP && first_q) begin
            if (hit) begin
                if (hits_q != '1) hits_q <= hits_q + STAT_W'(1);
            end else begin
                if (misses_q != '1) misses_q <= misses_q + STAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dcache_wb_ctrl.sv
// tb/tb_dcache_wb_ctrl.sv - self-checking bench for dcache_wb_ctrl
module tb_dcache_wb_ctrl;

    localparam int NUM_SETS    = 16;
    localparam int WORDS       = 16;
    localparam int STAT_W      = 32;
    localparam int LINE_BYTES  = WORDS * 4;
    localparam int CACHE_BYTES = LINE_BYTES * NUM_SETS;

    logic              clk;
    logic              reset;
    logic              cpu_req_valid;
    logic              cpu_req_ready;
    logic              cpu_req_we;
    logic [31:0]       cpu_req_addr;
    logic [31:0]       cpu_req_wdata;
    logic [3:0]        cpu_req_be;
    logic              cpu_resp_valid;
    logic [31:0]       cpu_resp_rdata;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_we;
    logic [31:0]       mem_req_addr;
    logic [31:0]       mem_req_wdata;
    logic              mem_resp_valid;
    logic [31:0]       mem_resp_rdata;
    logic [STAT_W-1:0] stat_hits;
    logic [STAT_W-1:0] stat_misses;

    dcache_wb_ctrl #(
        .NUM_SETS      (NUM_SETS),
        .WORDS_PER_LINE(WORDS),
        .STAT_W        (STAT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_req_valid (cpu_req_valid),
        .cpu_req_ready (cpu_req_ready),
        .cpu_req_we    (cpu_req_we),
        .cpu_req_addr  (cpu_req_addr),
        .cpu_req_wdata (cpu_req_wdata),
        .cpu_req_be    (cpu_req_be),
        .cpu_resp_valid(cpu_resp_valid),
        .cpu_resp_rdata(cpu_resp_rdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_we    (mem_req_we),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_rdata(mem_resp_rdata),
        .stat_hits     (stat_hits),
        .stat_misses   (stat_misses)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'd0, act}, {31'd0, exp});
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    beat_t       log_q[$];
    logic [31:0] backing [logic [31:0]];
    logic [31:0] golden  [logic [31:0]];
    logic [31:0] stall_addr = 32'hFFFF_FFFF;
    int          stall_left = 0;
    int          stall_seen = 0;
    bit          rand_ready = 1'b0;

    function automatic logic [31:0] pattern(input logic [31:0] a);
        return 32'hA000_0000 + (a >> 2);
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return backing.exists(a) ? backing[a] : pattern(a);
    endfunction

    function automatic logic [31:0] golden_rd(input logic [31:0] a);
        return golden.exists(a) ? golden[a] : pattern(a);
    endfunction

    // Memory environment: decides ready at the falling edge, logs beats, answers reads one cycle later
    initial begin : mem_env
        logic        rd_hs, wr_hs, prev_stall, p_valid, p_we;
        logic [31:0] a, d, p_addr, p_data;
        beat_t       bt;
        prev_stall     = 1'b0;
        mem_req_ready  = 1'b1;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        forever begin
            @(negedge clk);
            if (!reset && mem_req_valid && !mem_req_we && mem_req_addr == stall_addr && stall_left > 0) begin
                mem_req_ready = 1'b0;
                stall_left--;
                stall_seen++;
            end else if (rand_ready) begin
                mem_req_ready = ($urandom_range(0, 3) != 0);
            end else begin
                mem_req_ready = 1'b1;
            end
            if (prev_stall && !reset) begin
                chk1("stall_valid_stable", mem_req_valid, p_valid);
                chk1("stall_we_stable", mem_req_we, p_we);
                chk("stall_addr_stable", mem_req_addr, p_addr);
                chk("stall_wdata_stable", mem_req_wdata, p_data);
            end
            prev_stall = !reset && mem_req_valid && !mem_req_ready;
            p_valid = mem_req_valid;
            p_we    = mem_req_we;
            p_addr  = mem_req_addr;
            p_data  = mem_req_wdata;
            rd_hs   = mem_req_valid && mem_req_ready && !mem_req_we;
            wr_hs   = mem_req_valid && mem_req_ready && mem_req_we;
            a       = mem_req_addr;
            d       = mem_req_wdata;
            @(posedge clk);
            #1;
            mem_resp_valid = 1'b0;
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (wr_hs) begin
                    backing[a] = d;
                    bt.we = 1'b1; bt.addr = a; bt.data = d;
                    log_q.push_back(bt);
                end
                if (rd_hs) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_rdata = mem_rd(a);
                    bt.we = 1'b0; bt.addr = a; bt.data = 32'd0;
                    log_q.push_back(bt);
                end
            end
        end
    end

    // Transaction-level reference: which line each set holds, whether it has unsaved stores
    int ref_tag   [NUM_SETS];
    bit ref_valid [NUM_SETS];
    bit ref_dirty [NUM_SETS];
    int exp_hits   = 0;
    int exp_misses = 0;

    task automatic ref_reset();
        for (int i = 0; i < NUM_SETS; i++) begin
            ref_valid[i] = 1'b0;
            ref_dirty[i] = 1'b0;
            ref_tag[i]   = 0;
        end
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] be, output logic [31:0] rd, output int lat, output bit got);
        int n;
        @(negedge clk);
        cpu_req_valid = 1'b1;
        cpu_req_we    = we;
        cpu_req_addr  = addr;
        cpu_req_wdata = wd;
        cpu_req_be    = be;
        n = 0;
        while (!cpu_req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        cpu_req_valid = 1'b0;
        rd  = '0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 600) begin
            @(negedge clk);
            lat++;
            if (cpu_resp_valid) begin
                got = 1'b1;
                rd  = cpu_resp_rdata;
            end
        end
        @(negedge clk);
        chk1("resp_single_pulse", cpu_resp_valid, 1'b0);
    endtask

    task automatic run_check(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [3:0] be, input bit chk_lat, input int extra,
                             output logic [31:0] rd, output int n_wb, output int n_rd);
        int          s_idx, tag, old_tag, lat, exp_wb, exp_rd;
        bit          hit, got;
        logic [31:0] wa, w, ea;
        s_idx   = int'((addr / LINE_BYTES) % NUM_SETS);
        tag     = int'(addr / CACHE_BYTES);
        wa      = addr & ~32'd3;
        hit     = ref_valid[s_idx] && (ref_tag[s_idx] == tag);
        exp_wb  = (!hit && ref_valid[s_idx] && ref_dirty[s_idx]) ? WORDS : 0;
        exp_rd  = hit ? 0 : WORDS;
        old_tag = ref_tag[s_idx];
        log_q.delete();
        do_req(we, addr, wd, be, rd, lat, got);
        chk1("resp_seen", got, 1'b1);
        chk("resp_rdata", rd, we ? 32'd0 : golden_rd(wa));
        n_wb = 0;
        n_rd = 0;
        foreach (log_q[i]) begin
            if (log_q[i].we) begin
                ea = old_tag * CACHE_BYTES + s_idx * LINE_BYTES + n_wb * 4;
                chk("wb_before_refill", n_rd, 0);
                chk("wb_addr", log_q[i].addr, ea);
                chk("wb_data", log_q[i].data, golden_rd(ea));
                n_wb++;
            end else begin
                ea = tag * CACHE_BYTES + s_idx * LINE_BYTES + n_rd * 4;
                chk("refill_addr", log_q[i].addr, ea);
                n_rd++;
            end
        end
        chk("wb_beats", n_wb, exp_wb);
        chk("refill_beats", n_rd, exp_rd);
        // lookup cycle, writeback beats, request/wait pairs, replay lookup
        if (chk_lat) chk("latency", lat, hit ? 1 : 1 + exp_wb + 2 * WORDS + 1 + extra);
        if (hit) exp_hits++;
        else     exp_misses++;
        if (!hit) begin
            ref_valid[s_idx] = 1'b1;
            ref_tag[s_idx]   = tag;
            ref_dirty[s_idx] = 1'b0;
        end
        if (we) begin
            w = golden_rd(wa);
            for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
            golden[wa] = w;
            if (be != 4'b0000) ref_dirty[s_idx] = 1'b1;
        end
        chk("stat_hits", stat_hits, exp_hits);
        chk("stat_misses", stat_misses, exp_misses);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        int          exp_wb;
        int          exp_rd;
        int          exp_hits;
        int          exp_misses;
    } vec_t;

    vec_t vecs[5];

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] rd, addr, wd;
        logic        we;
        logic [3:0]  be;
        int          nwb, nrd, n;

        vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,          4'h0, 32'hA000_0004, 0,  16, 0, 1};
        vecs[1] = '{1'b0, 32'h0000_0014, 32'h0,          4'h0, 32'hA000_0005, 0,  0,  1, 1};
        vecs[2] = '{1'b1, 32'h0000_0010, 32'h1234_5678, 4'h3, 32'h0,          0,  0,  2, 1};
        vecs[3] = '{1'b0, 32'h0000_0010, 32'h0,          4'h0, 32'hA000_5678, 0,  0,  3, 1};
        vecs[4] = '{1'b0, 32'h0000_0410, 32'h0,          4'h0, 32'hA000_0104, 16, 16, 3, 2};

        reset         = 1'b1;
        cpu_req_valid = 1'b0;
        cpu_req_we    = 1'b0;
        cpu_req_addr  = '0;
        cpu_req_wdata = '0;
        cpu_req_be    = '0;
        ref_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk1("reset_req_ready", cpu_req_ready, 1'b1);
        chk1("reset_mem_req_valid", mem_req_valid, 1'b0);
        chk1("reset_resp_valid", cpu_resp_valid, 1'b0);
        chk("reset_hits", stat_hits, 32'd0);
        chk("reset_misses", stat_misses, 32'd0);

        for (int i = 0; i < 5; i++) begin
            run_check(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, 1'b1, 0, rd, nwb, nrd);
            chk("vec_rdata", rd, vecs[i].exp_rdata);
            chk("vec_wb_beats", nwb, vecs[i].exp_wb);
            chk("vec_refill_beats", nrd, vecs[i].exp_rd);
            chk("vec_hits", stat_hits, vecs[i].exp_hits);
            chk("vec_misses", stat_misses, vecs[i].exp_misses);
            if (i == 4) begin
                if (log_q.size() > 4) begin
                    chk("wb_beat4_addr", log_q[4].addr, 32'h0000_0010);
                    chk("wb_beat4_data", log_q[4].data, 32'hA000_5678);
                end else begin
                    chk("wb_beat4_present", log_q.size(), 32);
                end
            end
        end

        // Refill of line 0x00 with five stalled cycles on beat 3
        stall_addr = 32'h0000_000C;
        stall_left = 5;
        stall_seen = 0;
        run_check(1'b0, 32'h0000_000C, 32'h0, 4'h0, 1'b1, 5, rd, nwb, nrd);
        chk("stall_rdata", rd, 32'hA000_0003);
        chk("stall_cycles", stall_seen, 5);
        stall_addr = 32'hFFFF_FFFF;
        stall_left = 0;

        // Reset during refill beat 7 abandons the request and clears the cache
        @(negedge clk);
        cpu_req_valid = 1'b1;
        cpu_req_we    = 1'b0;
        cpu_req_addr  = 32'h0000_0810;
        @(posedge clk);
        #1;
        cpu_req_valid = 1'b0;
        n = 0;
        while (!(mem_req_valid && !mem_req_we && mem_req_addr == 32'h0000_081C) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk1("beat7_reached", n < 200, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        chk1("rst_mid_mem_req_valid", mem_req_valid, 1'b0);
        chk1("rst_mid_resp_valid", cpu_resp_valid, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        ref_reset();
        @(negedge clk);
        chk1("rst_mid_req_ready", cpu_req_ready, 1'b1);
        chk("rst_mid_hits", stat_hits, 32'd0);
        chk("rst_mid_misses", stat_misses, 32'd0);
        run_check(1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b1, 0, rd, nwb, nrd);
        chk("post_rst_rdata", rd, 32'hA000_5678);
        chk("post_rst_refill_beats", nrd, 16);
        chk("post_rst_misses", stat_misses, 32'd1);
        chk("post_rst_hits", stat_hits, 32'd0);

        // Random traffic over four sets and four tags with random memory backpressure
        rand_ready = 1'b1;
        for (int k = 0; k < 150; k++) begin
            addr = $urandom_range(0, 3) * CACHE_BYTES + $urandom_range(0, 3) * LINE_BYTES
                 + $urandom_range(0, WORDS - 1) * 4;
            we   = 1'($urandom_range(0, 1));
            be   = 4'($urandom);
            wd   = $urandom;
            run_check(we, addr, wd, be, 1'b0, 0, rd, nwb, nrd);
        end
        rand_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dcache_wb_ctrl.md
Name: dcache_wb_ctrl

Overview:
Parametrised direct-mapped, write-back, write-allocate data cache for the core's load/store path. It sits between the CPU load/store unit and data memory. CPU side uses a valid/ready request channel and a single-cycle response pulse. Memory side is a word-serial valid/ready port. An internal FSM performs line refill and dirty-line writeback. Hit and miss statistics counters are exported.

Parameters:
NUM_SETS, 16, number of cache lines; power of 2, >=2; INDEX_W = log2(NUM_SETS).
WORDS_PER_LINE, 16, 32-bit words per line; power of 2, >=2; OFFSET_W = log2(WORDS_PER_LINE).
STAT_W, 32, width of the statistics counters.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
cpu_req_valid  in  1  CPU request present
cpu_req_ready  out  1  cache accepts request (high only in IDLE)
cpu_req_we  in  1  1 = store, 0 = load
cpu_req_addr  in  32  byte address; bits [1:0] ignored
cpu_req_wdata  in  32  store data
cpu_req_be  in  4  store byte enables
cpu_resp_valid  out  1  one-cycle completion pulse
cpu_resp_rdata  out  32  load data, valid with cpu_resp_valid; 0 for stores
mem_req_valid  out  1  memory beat request
mem_req_ready  in  1  memory accepts beat
mem_req_we  out  1  1 = writeback beat, 0 = refill read
mem_req_addr  out  32  word-aligned beat address
mem_req_wdata  out  32  writeback data
mem_resp_valid  in  1  refill read data returned
mem_resp_rdata  in  32  refill word
stat_hits  out  STAT_W  saturating hit count
stat_misses  out  STAT_W  saturating miss count

Behaviour:
- Address split: offset = addr[OFFSET_W+1:2]; index = next INDEX_W bits; tag = remaining upper bits (defaults: [5:2], [9:6], [31:10]).
- State per line: valid, dirty, tag, data. Data storage is not reset.
- Reset (async):
  - valid and dirty cleared in all lines.
  - FSM goes to IDLE; counters are zeroed.
  - mem_req_valid = 0, cpu_resp_valid = 0, cpu_req_ready = 1 once reset is released.
  - Reset mid-operation abandons the transaction. A later mem_resp_valid is ignored unless the FSM is in REFILL_WAIT.
- IDLE:
  - cpu_req_ready = 1.
  - When cpu_req_valid is high, latch addr, we, wdata and be, then go to LOOKUP.
- LOOKUP: hit = valid[index] && tag match.
  - Load hit: cpu_resp_valid = 1 and rdata = line word, in this same cycle (response 1 cycle after acceptance) -> IDLE.
  - Store hit: merge the enabled bytes, set dirty if be != 0, pulse cpu_resp_valid -> IDLE.
  - Miss with valid and dirty: -> WRITEBACK.
  - Miss otherwise: -> REFILL_REQ.
  - stat_hits / stat_misses increment only on the first lookup of a request. Replay lookups are not counted.
- WRITEBACK:
  - Issue WORDS_PER_LINE beats in order, word 0 first: mem_req_we = 1, addr = {old tag, index, beat, 2'b00}.
  - A beat completes when mem_req_valid && mem_req_ready.
  - valid/we/addr/wdata must stay stable while ready is low.
  - After the last beat -> REFILL_REQ.
- REFILL_REQ:
  - mem_req_valid = 1, we = 0, addr = {new tag, index, beat, 2'b00}.
  - On handshake -> REFILL_WAIT.
- REFILL_WAIT:
  - On mem_resp_valid, write the word into the line.
  - If it is the last beat: set valid, write tag, clear dirty -> LOOKUP (replay, guaranteed hit). Otherwise -> REFILL_REQ.
  - Only one outstanding read at a time.
- Miss latency with ready and responses immediate: WB_beats + 2*WORDS_PER_LINE + 1 cycles before the response.
- cpu_resp_valid has no backpressure. cpu_req_ready is low in every state except IDLE.
- Counters saturate at all-ones.

Decomposition:
- Package dcache_pkg: FSM state enum (IDLE, LOOKUP, WRITEBACK, REFILL_REQ, REFILL_WAIT), a clog2-based width helper, and address-field extraction functions.
- Sub-module dcache_data_ram: NUM_SETS x WORDS_PER_LINE x 32 array with combinational read and synchronous write with 4-bit byte enable.
- Tag, valid and dirty storage plus the FSM stay in the top module.

Test Plan:
1. Reset, then load 0x00000010 with memory returning 0xA0000000+word -> 16 reads at 0x00..0x3C; resp rdata 0xA0000004; stat_misses = 1, stat_hits = 0.
2. Load 0x00000014 -> resp_valid 1 cycle after acceptance, rdata 0xA0000005, no mem_req_valid; stat_hits = 1.
3. Store 0x00000010 with wdata 0x12345678, be 4'b0011, then load 0x10 -> rdata 0xA0005678, no memory traffic.
4. Load 0x00000410 (index 0, tag 1) -> 16 write beats 0x00..0x3C, beat 4 wdata 0xA0005678; then 16 reads 0x400..0x43C; stat_misses = 2.
5. Hold mem_req_ready low 5 cycles during refill beat 3 -> mem_req_valid/addr stay stable at 0x0C; final data correct.
6. Assert reset at refill beat 7 -> mem_req_valid drops at once; after release cpu_req_ready = 1; load 0x10 misses again and counters restart from 0.
